// File: rtl/bcd_display_scan.sv
// Two-digit multiplexed seven-segment driver.
// Holds a tens/units BCD pair captured on a load strobe and alternates them
// onto a shared segment bus, each digit lit for REFRESH_DIV cycles. Digits
// above 9 are flagged on err and shown as "E". An optional leading-zero
// blank suppresses a tens digit of 0 while keeping its time slot.
// Outputs are Moore: decoded only from the held digits and the scan state.
module bcd_display_scan #(
    parameter int REFRESH_DIV = 4,
    parameter bit BLANK_LEAD  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] s1,
    input  logic [3:0] s0,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       err,
    output logic [1:0] dbg_state
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_E = 7'h79;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        UNITS = 2'd1,
        TENS  = 2'd2
    } state_t;

    state_t        r_state;
    logic [3:0]    r_t;
    logic [3:0]    r_u;
    logic [CW-1:0] r_cnt;

    logic       w_err;
    logic       w_blank;
    logic [6:0] w_seg;
    logic [1:0] w_an;

    // Segment pattern {g,f,e,d,c,b,a} for a BCD digit; non-BCD codes map dark.
    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h00;
        endcase
    endfunction

    // Scan FSM: capture on load in any non-reset state; the refresh counter
    // and digit phase advance independently of load so reloads never shift
    // the scan timing. Only reset returns to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_t     <= 4'd0;
            r_u     <= 4'd0;
            r_cnt   <= '0;
        end else begin
            if (load) begin
                r_t <= s1;
                r_u <= s0;
            end
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (load) begin
                        r_state <= UNITS;
                    end
                end
                UNITS, TENS: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= (r_state == UNITS) ? TENS : UNITS;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Display decode from held state; error forces "E" and disables blanking.
    always_comb begin
        w_err   = (r_t > 4'd9) || (r_u > 4'd9);
        w_blank = BLANK_LEAD && (r_t == 4'd0) && !w_err;
        w_seg   = 7'h00;
        w_an    = 2'b00;
        case (r_state)
            UNITS: begin
                w_an  = 2'b01;
                w_seg = w_err ? SEG_E : decode(r_u);
            end
            TENS: begin
                if (!w_blank) begin
                    w_an  = 2'b10;
                    w_seg = w_err ? SEG_E : decode(r_t);
                end
            end
            default: begin
                w_an  = 2'b00;
                w_seg = 7'h00;
            end
        endcase
    end

    assign seg       = w_seg;
    assign an        = w_an;
    assign err       = w_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Bench for bcd_display_scan. Three instances share stimulus:
// dut (DIV=4, blanking on), dut_nb (DIV=4, blanking off), dut_r1 (DIV=1).
// Each cycle the expected {an, seg, err} word is queued when stimulus is
// driven and popped/compared on the following falling edge.
module tb_bcd_display_scan;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [3:0] s1 = 4'd0;
  logic [3:0] s0 = 4'd0;

  logic [6:0] seg_a, seg_b, seg_c;
  logic [1:0] an_a, an_b, an_c;
  logic       err_a, err_b, err_c;
  logic [1:0] st_a, st_b, st_c;

  logic [9:0] exp_q[$];
  int chk_cnt = 0;
  int pass_cnt = 0;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  bcd_display_scan #(.REFRESH_DIV(4), .BLANK_LEAD(1'b1)) dut (
    .clk(clk), .reset(reset), .load(load), .s1(s1), .s0(s0),
    .seg(seg_a), .an(an_a), .err(err_a), .dbg_state(st_a)
  );

  bcd_display_scan #(.REFRESH_DIV(4), .BLANK_LEAD(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .load(load), .s1(s1), .s0(s0),
    .seg(seg_b), .an(an_b), .err(err_b), .dbg_state(st_b)
  );

  bcd_display_scan #(.REFRESH_DIV(1), .BLANK_LEAD(1'b1)) dut_r1 (
    .clk(clk), .reset(reset), .load(load), .s1(s1), .s0(s0),
    .seg(seg_c), .an(an_c), .err(err_c), .dbg_state(st_c)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Reference: expected word for scan index idx after the first load.
  function automatic logic [9:0] model(input logic [3:0] t, input logic [3:0] u,
                                       input int rd, input bit blank, input int idx);
    logic e;
    logic tens;
    e = (t > 4'd9) || (u > 4'd9);
    tens = ((idx / rd) % 2) == 1;
    if (!tens)
      return {2'b01, (e ? 7'h79 : seg_tab[u]), e};
    else if (blank && t == 4'd0 && !e)
      return {2'b00, 7'h00, 1'b0};
    else
      return {2'b10, (e ? 7'h79 : seg_tab[t]), e};
  endfunction

  function automatic logic [9:0] observe(input int sel);
    case (sel)
      0: return {an_a, seg_a, err_a};
      1: return {an_b, seg_b, err_b};
      default: return {an_c, seg_c, err_c};
    endcase
  endfunction

  // driver: one-cycle reset, returns on a falling edge
  task automatic do_reset();
    reset = 1'b1;
    load = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] obs, exp;
    reset = 1'b1; load = 1'b1; s1 = 4'd3; s0 = 4'd7;
    for (int i = 0; i < 5; i++) exp_q.push_back(10'h000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 1) begin reset = 1'b0; load = 1'b0; end
      for (int k = 0; k < 3; k++) begin
        obs = observe(k);
        exp = exp_q[0];
        chk_cnt++;
        if (obs !== exp)
          $display("FAIL reset cyc %0d inst %0d: got %h want %h", i, k, obs, exp);
        else pass_cnt++;
      end
      chk_cnt++;
      if (st_a !== 2'd0) $display("FAIL reset_idle_state cyc %0d: got %0d want 0", i, st_a);
      else pass_cnt++;
      void'(exp_q.pop_front());
    end
    // first load after reset leaves IDLE
    load = 1'b1;
    exp_q.push_back(model(4'd3, 4'd7, 4, 1'b1, 0));
    @(negedge clk);
    load = 1'b0;
    obs = observe(0);
    exp = exp_q.pop_front();
    chk_cnt++;
    if (obs !== exp) $display("FAIL reset_first_load: got %h want %h", obs, exp);
    else pass_cnt++;
  endtask

  task automatic test_normal_scan();
    logic [9:0] obs, exp;
    do_reset();
    load = 1'b1; s1 = 4'd1; s0 = 4'd9;
    for (int i = 0; i < 16; i++) exp_q.push_back(model(4'd1, 4'd9, 4, 1'b1, i));
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      load = 1'b0;
      obs = observe(0);
      exp = exp_q.pop_front();
      chk_cnt++;
      if (obs !== exp) $display("FAIL normal_scan cyc %0d: got %h want %h", i, obs, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_leading_zero();
    logic [9:0] obs, exp;
    for (int sel = 0; sel < 2; sel++) begin
      do_reset();
      load = 1'b1; s1 = 4'd0; s0 = 4'd5;
      for (int i = 0; i < 8; i++)
        exp_q.push_back(model(4'd0, 4'd5, 4, (sel == 0), i));
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        load = 1'b0;
        obs = observe(sel);
        exp = exp_q.pop_front();
        chk_cnt++;
        if (obs !== exp)
          $display("FAIL leading_zero blank=%0d cyc %0d: got %h want %h", (sel == 0), i, obs, exp);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_invalid_bcd();
    logic [9:0] obs, exp;
    do_reset();
    load = 1'b1; s1 = 4'd1; s0 = 4'hA;
    for (int i = 0; i < 8; i++) exp_q.push_back(model(4'd1, 4'hA, 4, 1'b1, i));
    for (int i = 8; i < 12; i++) exp_q.push_back(model(4'd0, 4'd9, 4, 1'b1, i));
    for (int i = 12; i < 20; i++) exp_q.push_back(model(4'd0, 4'hB, 4, 1'b1, i));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 7) begin load = 1'b1; s1 = 4'd0; s0 = 4'd9; end
      else if (i == 11) begin load = 1'b1; s1 = 4'd0; s0 = 4'hB; end
      else load = 1'b0;
      obs = observe(0);
      exp = exp_q.pop_front();
      chk_cnt++;
      if (obs !== exp) $display("FAIL invalid_bcd cyc %0d: got %h want %h", i, obs, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_midscan_reload();
    logic [9:0] obs, exp;
    do_reset();
    load = 1'b1; s1 = 4'd2; s0 = 4'd3;
    for (int i = 0; i < 2; i++) exp_q.push_back(model(4'd2, 4'd3, 4, 1'b1, i));
    for (int i = 2; i < 10; i++) exp_q.push_back(model(4'd4, 4'd6, 4, 1'b1, i));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 1) begin load = 1'b1; s1 = 4'd4; s0 = 4'd6; end
      else load = 1'b0;
      obs = observe(0);
      exp = exp_q.pop_front();
      chk_cnt++;
      if (obs !== exp) $display("FAIL midscan_reload cyc %0d: got %h want %h", i, obs, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] obs, exp;
    bit         ld_tab [8] = '{1, 1, 1, 0, 1, 0, 0, 0};
    logic [3:0] t_tab [8] = '{4'd1, 4'd2, 4'd5, 4'd0, 4'd8, 4'd0, 4'd0, 4'd0};
    logic [3:0] u_tab [8] = '{4'd1, 4'd2, 4'd7, 4'd0, 4'd3, 4'd0, 4'd0, 4'd0};
    logic [3:0] ht, hu;
    do_reset();
    ht = 4'd0; hu = 4'd0;
    for (int i = 0; i < 8; i++) begin
      load = ld_tab[i]; s1 = t_tab[i]; s0 = u_tab[i];
      if (ld_tab[i]) begin ht = t_tab[i]; hu = u_tab[i]; end
      exp_q.push_back(model(ht, hu, 4, 1'b1, i));
      @(negedge clk);
      obs = observe(0);
      exp = exp_q.pop_front();
      chk_cnt++;
      if (obs !== exp) $display("FAIL back_to_back cyc %0d: got %h want %h", i, obs, exp);
      else pass_cnt++;
    end
    load = 1'b0;
  endtask

  task automatic test_div1_reset();
    logic [9:0] obs, exp;
    do_reset();
    load = 1'b1; s1 = 4'd1; s0 = 4'd9;
    for (int i = 0; i < 6; i++) exp_q.push_back(model(4'd1, 4'd9, 1, 1'b1, i));
    for (int i = 0; i < 4; i++) exp_q.push_back(10'h000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      load = 1'b0;
      if (i == 5) reset = 1'b1;
      else reset = 1'b0;
      obs = observe(2);
      exp = exp_q.pop_front();
      chk_cnt++;
      if (obs !== exp) $display("FAIL div1_reset cyc %0d: got %h want %h", i, obs, exp);
      else pass_cnt++;
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_normal_scan();
    test_leading_zero();
    test_invalid_bcd();
    test_midscan_reload();
    test_back_to_back();
    test_div1_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
